// File: rtl/dart_sensor.sv
// Dart board sensor front end: synchronizes and debounces the raw hit level, queues hit
// positions in a small FIFO and issues them to the scoring stage at a minimum spacing.
module dart_sensor #(
  parameter int DEBOUNCE = 4,
  parameter int GAP      = 8,
  parameter int DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    hit_raw_i,
  input  logic [7:0]              hit_x_i,
  input  logic [7:0]              hit_y_i,
  input  logic                    game_set_i,
  output logic                    dart_come_o,
  output logic [7:0]              dart_position_x_o,
  output logic [7:0]              dart_position_y_o,
  output logic                    drop_o,
  output logic [$clog2(DEPTH):0]  fifo_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0]    DEB_M1   = 4'(DEBOUNCE - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [7:0]    GAP_LOAD = 8'(GAP - 1);

  typedef enum logic [1:0] {IDLE, ARM, HELD, REL} state_t;

  logic [1:0]    sync_q;
  logic          hs;
  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          accept;

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    gap_q, gap_d;
  logic          come_q, come_d;
  logic          drop_q, drop_d;
  logic [7:0]    pos_x_q, pos_x_d;
  logic [7:0]    pos_y_q, pos_y_d;

  logic          full, empty, issue, push_req, push;
  logic [15:0]   head;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], hit_raw_i};
    end
  end

  assign hs = sync_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // With DEBOUNCE=1 a single high or low sample is enough, so ARM/REL are skipped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          if (DEBOUNCE == 1) begin
            state_d = HELD;
            cnt_d   = 4'd0;
          end else begin
            state_d = ARM;
            cnt_d   = 4'd1;
          end
        end
      end
      ARM: begin
        if (!hs) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == DEB_M1) begin
          state_d = HELD;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HELD: begin
        if (!hs) begin
          if (DEBOUNCE == 1) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end else begin
            state_d = REL;
            cnt_d   = 4'd1;
          end
        end
      end
      REL: begin
        if (hs) begin
          state_d = HELD;
          cnt_d   = 4'd0;
        end else if (cnt_q == DEB_M1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    accept = 1'b0;
    if (state_q == ARM && hs && cnt_q == DEB_M1) begin
      accept = 1'b1;
    end else if (state_q == IDLE && hs && DEBOUNCE == 1) begin
      accept = 1'b1;
    end
  end

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign issue    = !empty && (gap_q == 8'd0) && !game_set_i;
  assign push_req = accept && !game_set_i;
  assign push     = push_req && (!full || issue);
  assign head     = mem_q[rd_ptr_q];

  // Entries are read only through the pointers, so the storage itself needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {hit_x_i, hit_y_i};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = push_req && full && !issue;
    come_d   = issue;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    gap_d    = (gap_q != 8'd0) ? gap_q - 8'd1 : gap_q;
    if (game_set_i) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (issue) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        gap_d    = GAP_LOAD;
        pos_x_d  = head[15:8];
        pos_y_d  = head[7:0];
      end
      unique case ({push, issue})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      gap_q    <= 8'd0;
      come_q   <= 1'b0;
      drop_q   <= 1'b0;
      pos_x_q  <= 8'd0;
      pos_y_q  <= 8'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      gap_q    <= gap_d;
      come_q   <= come_d;
      drop_q   <= drop_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
    end
  end

  assign dart_come_o       = come_q;
  assign drop_o            = drop_q;
  assign dart_position_x_o = pos_x_q;
  assign dart_position_y_o = pos_y_q;
  assign fifo_count_o      = count_q;

endmodule

// File: tb/tb_dart_sensor.sv
// Directed bench for dart_sensor (DEBOUNCE=4, GAP=40, DEPTH=4). Inputs change on the falling
// edge; step t samples outputs that reflect rising edges 0..t-1 and then drives edge t.
module tb_dart_sensor;

  logic       clk;
  logic       reset;
  logic       hit_raw_i;
  logic [7:0] hit_x_i;
  logic [7:0] hit_y_i;
  logic       game_set_i;
  logic       dart_come_o;
  logic [7:0] dart_position_x_o;
  logic [7:0] dart_position_y_o;
  logic       drop_o;
  logic [2:0] fifo_count_o;

  int checks;
  int failures;

  dart_sensor #(.DEBOUNCE(4), .GAP(40), .DEPTH(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .hit_raw_i         (hit_raw_i),
    .hit_x_i           (hit_x_i),
    .hit_y_i           (hit_y_i),
    .game_set_i        (game_set_i),
    .dart_come_o       (dart_come_o),
    .dart_position_x_o (dart_position_x_o),
    .dart_position_y_o (dart_position_y_o),
    .drop_o            (drop_o),
    .fifo_count_o      (fifo_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    reset      = 1'b1;
    hit_raw_i  = 1'b0;
    game_set_i = 1'b0;
    hit_x_i    = 8'd0;
    hit_y_i    = 8'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    hit_raw_i  = 1'b1;
    game_set_i = 1'b0;
    hit_x_i    = 8'd9;
    hit_y_i    = 8'd9;
    #2;
    checks++;
    if ({dart_come_o, drop_o, dart_position_x_o, dart_position_y_o, fifo_count_o} !== 19'd0) begin
      failures++;
      $display("FAIL reset_outputs got come=%b drop=%b x=%0d y=%0d cnt=%0d exp all zero",
               dart_come_o, drop_o, dart_position_x_o, dart_position_y_o, fifo_count_o);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (dart_come_o !== 1'b0 || fifo_count_o !== 3'd0) begin
      failures++;
      $display("FAIL reset_held got come=%b cnt=%0d exp come=0 cnt=0", dart_come_o, fifo_count_o);
    end
  endtask

  // Raw high for 20 cycles: one strobe in step 7 carrying 100/120, then silence.
  task automatic test_clean_press();
    logic exp_come;
    do_reset();
    for (int t = 0; t <= 70; t++) begin
      if (t > 0) begin
        @(negedge clk);
        exp_come = (t == 7);
        checks++;
        if (dart_come_o !== exp_come) begin
          failures++;
          $display("FAIL clean_come t=%0d got=%b exp=%b", t, dart_come_o, exp_come);
        end
      end
      if (t == 6) begin
        checks++;
        if (fifo_count_o !== 3'd1) begin
          failures++;
          $display("FAIL clean_count t=%0d got=%0d exp=1", t, fifo_count_o);
        end
      end
      if (t == 7 || t == 40) begin
        checks++;
        if (dart_position_x_o !== 8'd100 || dart_position_y_o !== 8'd120) begin
          failures++;
          $display("FAIL clean_pos t=%0d got=%0d/%0d exp=100/120", t, dart_position_x_o, dart_position_y_o);
        end
      end
      hit_raw_i = (t < 20);
      hit_x_i   = 8'd100;
      hit_y_i   = 8'd120;
    end
  endtask

  // Bouncy press then a 2-cycle release glitch while held: only the strobe in step 12.
  task automatic test_bounce();
    logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic exp_come;
    do_reset();
    for (int t = 0; t <= 90; t++) begin
      if (t > 0) begin
        @(negedge clk);
        exp_come = (t == 12);
        checks++;
        if (dart_come_o !== exp_come || drop_o !== 1'b0) begin
          failures++;
          $display("FAIL bounce_come t=%0d got come=%b drop=%b exp come=%b drop=0",
                   t, dart_come_o, drop_o, exp_come);
        end
      end
      if (t == 12) begin
        checks++;
        if (dart_position_x_o !== 8'd55 || dart_position_y_o !== 8'd66) begin
          failures++;
          $display("FAIL bounce_pos got=%0d/%0d exp=55/66", dart_position_x_o, dart_position_y_o);
        end
      end
      if (t < 5)                    hit_raw_i = pat[t];
      else if (t < 15)              hit_raw_i = 1'b1;
      else if (t < 17)              hit_raw_i = 1'b0;
      else if (t < 22)              hit_raw_i = 1'b1;
      else                          hit_raw_i = 1'b0;
      hit_x_i = 8'd55;
      hit_y_i = 8'd66;
    end
  endtask

  // Eight presses: hits land on edges 5,13,21,29,37,46,54,62 and pops on 6,46,86,...
  // Edge 46 pushes and pops with the FIFO full; hits 6 and 7 are dropped.
  task automatic test_burst();
    int   starts [8] = '{0, 8, 16, 24, 32, 41, 49, 57};
    int   pulse_t [6] = '{7, 47, 87, 127, 167, 207};
    int   idx;
    logic exp_come, exp_drop;
    logic [2:0] max_cnt;
    do_reset();
    max_cnt = 3'd0;
    for (int t = 0; t <= 220; t++) begin
      if (t > 0) begin
        @(negedge clk);
        idx = -1;
        for (int k = 0; k < 6; k++) if (pulse_t[k] == t) idx = k;
        exp_come = (idx >= 0);
        exp_drop = (t == 55) || (t == 63);
        checks++;
        if (dart_come_o !== exp_come || drop_o !== exp_drop) begin
          failures++;
          $display("FAIL burst_strobe t=%0d got come=%b drop=%b exp come=%b drop=%b",
                   t, dart_come_o, drop_o, exp_come, exp_drop);
        end
        if (idx >= 0) begin
          checks++;
          if (dart_position_x_o !== 8'(10 + idx) || dart_position_y_o !== 8'(200 - idx)) begin
            failures++;
            $display("FAIL burst_order t=%0d got=%0d/%0d exp=%0d/%0d", t,
                     dart_position_x_o, dart_position_y_o, 10 + idx, 200 - idx);
          end
        end
        if (fifo_count_o > max_cnt) max_cnt = fifo_count_o;
      end
      if (t == 38 || t == 47 || t == 60) begin
        checks++;
        if (fifo_count_o !== 3'd4) begin
          failures++;
          $display("FAIL burst_full t=%0d got=%0d exp=4", t, fifo_count_o);
        end
      end
      if (t == 210) begin
        checks++;
        if (fifo_count_o !== 3'd0) begin
          failures++;
          $display("FAIL burst_drain got=%0d exp=0", fifo_count_o);
        end
      end
      hit_raw_i = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (t >= starts[k] && t < starts[k] + 4) hit_raw_i = 1'b1;
        if (t == starts[k]) begin
          hit_x_i = 8'(10 + k);
          hit_y_i = 8'(200 - k);
        end
      end
    end
    checks++;
    if (max_cnt !== 3'd4) begin
      failures++;
      $display("FAIL burst_max_count got=%0d exp=4", max_cnt);
    end
  endtask

  // Two entries queued, game over on edge 24 flushes them; a hit during game over is lost silently.
  task automatic test_game_over();
    int   starts [4] = '{0, 8, 16, 30};
    logic exp_come;
    do_reset();
    for (int t = 0; t <= 130; t++) begin
      if (t > 0) begin
        @(negedge clk);
        exp_come = (t == 7);
        checks++;
        if (dart_come_o !== exp_come || drop_o !== 1'b0) begin
          failures++;
          $display("FAIL game_strobe t=%0d got come=%b drop=%b exp come=%b drop=0",
                   t, dart_come_o, drop_o, exp_come);
        end
      end
      if (t == 22) begin
        checks++;
        if (fifo_count_o !== 3'd2) begin
          failures++;
          $display("FAIL game_queued got=%0d exp=2", fifo_count_o);
        end
      end
      if (t == 25 || t == 36 || t == 100) begin
        checks++;
        if (fifo_count_o !== 3'd0) begin
          failures++;
          $display("FAIL game_flush t=%0d got=%0d exp=0", t, fifo_count_o);
        end
      end
      game_set_i = (t >= 24 && t < 60);
      hit_raw_i  = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (t >= starts[k] && t < starts[k] + 4) hit_raw_i = 1'b1;
        if (t == starts[k]) begin
          hit_x_i = 8'(40 + k);
          hit_y_i = 8'(50 + k);
        end
      end
    end
    game_set_i = 1'b0;
  endtask

  // Three entries queued and a fifth press mid-debounce when reset hits; then a clean press.
  task automatic test_reset_midop();
    int   starts [5] = '{0, 8, 16, 24, 32};
    logic exp_come;
    do_reset();
    for (int t = 0; t < 36; t++) begin
      if (t > 0) @(negedge clk);
      hit_raw_i = 1'b0;
      for (int k = 0; k < 5; k++) begin
        if (t >= starts[k] && t < starts[k] + 4) hit_raw_i = 1'b1;
        if (t == starts[k]) begin
          hit_x_i = 8'(30 + k);
          hit_y_i = 8'(70 + k);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (fifo_count_o !== 3'd3 || dart_position_x_o !== 8'd30 || dart_position_y_o !== 8'd70) begin
      failures++;
      $display("FAIL midop_before got cnt=%0d pos=%0d/%0d exp cnt=3 pos=30/70",
               fifo_count_o, dart_position_x_o, dart_position_y_o);
    end
    #1 reset = 1'b1;
    hit_raw_i = 1'b0;
    #1;
    checks++;
    if ({dart_come_o, drop_o, dart_position_x_o, dart_position_y_o, fifo_count_o} !== 19'd0) begin
      failures++;
      $display("FAIL midop_async got come=%b drop=%b x=%0d y=%0d cnt=%0d exp all zero",
               dart_come_o, drop_o, dart_position_x_o, dart_position_y_o, fifo_count_o);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int t = 0; t <= 60; t++) begin
      if (t > 0) begin
        @(negedge clk);
        exp_come = (t == 7);
        checks++;
        if (dart_come_o !== exp_come) begin
          failures++;
          $display("FAIL midop_come t=%0d got=%b exp=%b", t, dart_come_o, exp_come);
        end
      end
      if (t == 7) begin
        checks++;
        if (dart_position_x_o !== 8'd77 || dart_position_y_o !== 8'd88) begin
          failures++;
          $display("FAIL midop_pos got=%0d/%0d exp=77/88", dart_position_x_o, dart_position_y_o);
        end
      end
      hit_raw_i = (t < 10);
      hit_x_i   = 8'd77;
      hit_y_i   = 8'd88;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_burst();
    test_game_over();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
